// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline constants for the hazard controller: default field widths,
// mult/div latencies, per-class Tuse/Tnew values and the forward-select width helper.
package hazard_ctrl_pkg;

    localparam int unsigned TW_DEF      = 3;
    localparam int unsigned MUL_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF = 10;

    // Cycles after ID until the result exists at a stage output
    localparam int unsigned TNEW_NONE   = 0;
    localparam int unsigned TNEW_ALU    = 1;
    localparam int unsigned TNEW_LOAD   = 2;
    localparam int unsigned TNEW_MFHILO = 1;

    // Cycles after ID until an operand is consumed
    localparam int unsigned TUSE_BRANCH = 0;
    localparam int unsigned TUSE_ALU    = 1;
    localparam int unsigned TUSE_STORE  = 2;

    typedef enum logic {
        MdMul = 1'b0,
        MdDiv = 1'b1
    } md_kind_e;

    // Forward-select width: encodes "register file" plus one code per tracked stage
    function automatic int unsigned sel_width(input int unsigned num_stages);
        return (num_stages < 2) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Mult/div busy counter: loads the unit latency on issue and counts down to idle.
module hazard_ctrl_md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYC = MUL_CYC_DEF,
    parameter int unsigned DIV_CYC = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int unsigned MaxCyc = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int unsigned CntW   = (MaxCyc < 2) ? 1 : $clog2(MaxCyc + 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    md_kind_e        kind;

    // Next count: a new issue reloads and takes precedence over the decrement
    always_comb begin
        kind  = md_kind_e'(md_is_div);
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = (kind == MdDiv) ? CntW'(DIV_CYC) : CntW'(MUL_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter state with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = ~reset & (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: private scoreboard of in-flight GPR writes, ID-stage
// stall and forward-select generation, and HI/LO interlock against the mult/div unit.
// Optional HAZARD_STATS_EN adds stall_cnt and md_stall_cnt performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned TW         = TW_DEF,
    parameter int unsigned MUL_CYC    = MUL_CYC_DEF,
    parameter int unsigned DIV_CYC    = DIV_CYC_DEF,
    localparam int unsigned SW        = sel_width(NUM_STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RPORTS*5-1:0]  id_raddr,
    input  logic [NUM_RPORTS*TW-1:0] id_tuse,
    input  logic [4:0]               id_waddr,
    input  logic [TW-1:0]            id_tnew,
    input  logic                     id_is_md,
    input  logic                     md_start,
    input  logic                     md_is_div,
    output logic                     stall,
    output logic [NUM_RPORTS*SW-1:0] fwd_sel,
    output logic                     md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              md_stall_cnt
`endif
);

    // Entry s describes the write held by tracked stage s (0 = EX)
    logic [4:0]    sb_waddr_d [NUM_STAGES];
    logic [4:0]    sb_waddr_q [NUM_STAGES];
    logic [TW-1:0] sb_tnew_d  [NUM_STAGES];
    logic [TW-1:0] sb_tnew_q  [NUM_STAGES];

    logic                     data_haz;
    logic                     md_haz;
    logic                     stall_raw;
    logic [NUM_RPORTS*SW-1:0] fwd_raw;

    hazard_ctrl_md_busy_ctr #(
        .MUL_CYC (MUL_CYC),
        .DIV_CYC (DIV_CYC)
    ) u_md_busy_ctr (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // Per read port: the youngest matching stage alone decides stall and forward
    always_comb begin : p_match
        logic [4:0]    raddr;
        logic [TW-1:0] tuse;
        logic          hit;
        data_haz = 1'b0;
        fwd_raw  = '0;
        raddr    = '0;
        tuse     = '0;
        hit      = 1'b0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            raddr = id_raddr[5*p +: 5];
            tuse  = id_tuse[TW*p +: TW];
            hit   = 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (!hit && raddr != 5'd0 && sb_waddr_q[s] == raddr) begin
                    hit = 1'b1;
                    if (sb_tnew_q[s] > tuse) begin
                        data_haz = 1'b1;
                    end
                    // A younger match with tnew>0 leaves fwd at 0; EX/MEM forwarding covers it
                    if (sb_tnew_q[s] == '0) begin
                        fwd_raw[SW*p +: SW] = SW'(s + 1);
                    end
                end
            end
        end
    end

    // Stall sources and reset-gated outputs
    always_comb begin
        md_haz    = id_is_md & (md_busy | md_start);
        stall_raw = data_haz | md_haz;
        stall     = ~reset & stall_raw;
        fwd_sel   = reset ? '0 : fwd_raw;
    end

    // Scoreboard ageing: a stall injects a bubble into EX, older entries always advance
    always_comb begin
        sb_waddr_d[0] = stall_raw ? 5'd0 : id_waddr;
        sb_tnew_d[0]  = (stall_raw || id_tnew == '0) ? '0 : id_tnew - 1'b1;
        for (int s = 1; s < NUM_STAGES; s++) begin
            sb_waddr_d[s] = sb_waddr_q[s-1];
            sb_tnew_d[s]  = (sb_tnew_q[s-1] == '0) ? '0 : sb_tnew_q[s-1] - 1'b1;
        end
    end

    // Scoreboard state with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_waddr_q <= '{default: '0};
            sb_tnew_q  <= '{default: '0};
        end else begin
            sb_waddr_q <= sb_waddr_d;
            sb_tnew_q  <= sb_tnew_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] md_stall_cnt_d, md_stall_cnt_q;

    // Counters wrap naturally; MDU-only means the data hazard term is clear
    always_comb begin
        stall_cnt_d    = stall_cnt_q + {31'd0, stall};
        md_stall_cnt_d = md_stall_cnt_q + {31'd0, stall & ~data_haz};
    end

    // Statistics state with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
